// File: rtl/bus_buffer_arbiter.sv
// Round-robin owner of the buffered system bus: one-hot grant, active-low buffer
// enables, enforced dead cycles between owners and a bounded hold time.
module bus_buffer_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int TURNAROUND = 1,
  parameter int MAX_HOLD   = 16,
  localparam int IW = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] grant,
  output logic [NUM_REQ-1:0] oe_n,
  output logic [IW-1:0]      grant_id,
  output logic               bus_busy,
  output logic               preempt
);
  // state | meaning
  // IDLE  | bus free, no driver enabled
  // GRANT | grant_id owns the bus, its buffer enabled
  // TURN  | dead cycles after a release, all buffers off
  typedef enum logic [1:0] {IDLE, GRANT, TURN} state_t;

  localparam int HW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam int TW = (TURNAROUND > 1) ? $clog2(TURNAROUND) : 1;
  localparam logic [HW-1:0] HOLD_MAX  = HW'(MAX_HOLD);
  localparam logic [HW-1:0] HOLD_LAST = HW'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);
  localparam logic [TW-1:0] TURN_INIT = TW'(TURNAROUND - 1);
  localparam logic [IW:0]   NREQ      = (IW+1)'(NUM_REQ);
  localparam logic [IW-1:0] LAST_IDX  = IW'(NUM_REQ - 1);

  state_t              state, state_n;
  logic [NUM_REQ-1:0]  grant_n;
  logic [IW-1:0]       grant_id_n, rr_ptr, rr_ptr_n, win_idx;
  logic [HW-1:0]       hold_cnt, hold_n;
  logic [TW-1:0]       turn_cnt, turn_n;
  logic                preempt_n, win_found, take_bus, others_waiting;
  logic [IW:0]         cand;

  // Rotating priority scan starting at rr_ptr.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, rr_ptr} + (IW+1)'(k);
      if (cand >= NREQ) cand = cand - NREQ;
      if (!win_found && req[cand[IW-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[IW-1:0];
      end
    end
  end

  assign others_waiting = |(req & ~grant);

  always_comb begin
    state_n    = state;
    grant_n    = '0;
    grant_id_n = grant_id;
    rr_ptr_n   = rr_ptr;
    hold_n     = hold_cnt;
    turn_n     = turn_cnt;
    preempt_n  = 1'b0;
    take_bus   = 1'b0;
    case (state)
      IDLE: begin
        if (win_found) take_bus = 1'b1;
      end
      GRANT: begin
        if (MAX_HOLD != 0 && hold_cnt != HOLD_MAX) hold_n = hold_cnt + 1'b1;
        if (!req[grant_id]) begin
          state_n = TURN;
          turn_n  = TURN_INIT;
        // >= so a holder that saturated the counter while alone still yields later
        end else if (MAX_HOLD != 0 && hold_cnt >= HOLD_LAST && others_waiting) begin
          state_n   = TURN;
          turn_n    = TURN_INIT;
          preempt_n = 1'b1;
        end else begin
          grant_n = grant;
        end
      end
      TURN: begin
        if (turn_cnt == '0) begin
          if (win_found) take_bus = 1'b1;
          else           state_n  = IDLE;
        end else begin
          turn_n = turn_cnt - 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
    if (take_bus) begin
      state_n    = GRANT;
      grant_n    = NUM_REQ'(1) << win_idx;
      grant_id_n = win_idx;
      rr_ptr_n   = (win_idx == LAST_IDX) ? '0 : win_idx + 1'b1;
      hold_n     = '0;
    end
  end

  // Outputs are flops so a reset drops every buffer enable without waiting for a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      grant    <= '0;
      oe_n     <= '1;
      grant_id <= '0;
      bus_busy <= 1'b0;
      preempt  <= 1'b0;
      rr_ptr   <= '0;
      hold_cnt <= '0;
      turn_cnt <= '0;
    end else begin
      state    <= state_n;
      grant    <= grant_n;
      oe_n     <= ~grant_n;
      grant_id <= grant_id_n;
      bus_busy <= (state_n == GRANT);
      preempt  <= preempt_n;
      rr_ptr   <= rr_ptr_n;
      hold_cnt <= hold_n;
      turn_cnt <= turn_n;
    end
  end
endmodule

// File: tb/tb_bus_buffer_arbiter.sv
// Scoreboard bench for bus_buffer_arbiter: a cycle model pushes expected outputs
// as each request pattern is driven; they are popped and compared after the edge.
module tb_bus_buffer_arbiter;
  localparam int N  = 4;
  localparam int TA = 1;
  localparam int MH = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] req = '0;
  logic [N-1:0] grant, oe_n;
  logic [1:0]   grant_id;
  logic         bus_busy, preempt;

  bus_buffer_arbiter #(.NUM_REQ(N), .TURNAROUND(TA), .MAX_HOLD(MH)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .grant(grant), .oe_n(oe_n),
    .grant_id(grant_id), .bus_busy(bus_busy), .preempt(preempt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] g;
    logic [3:0] oe;
    logic [1:0] id;
    logic       busy;
    logic       pre;
  } exp_t;

  exp_t       sb[$];
  int         n_checks = 0;
  int         n_errors = 0;
  int         n_preempt = 0;
  logic [3:0] prev_g = '0;

  // model state: 0 idle, 1 grant, 2 turn
  int m_st, m_gid, m_rr, m_hold, m_turn;
  logic [3:0] m_g;
  logic       m_pre;

  assert property (@(posedge clk) disable iff (!rst_n) $onehot0(grant));
  assert property (@(posedge clk) disable iff (!rst_n)
                   (grant != '0 && $past(grant) != '0) |-> grant == $past(grant));

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_gid = 0; m_rr = 0; m_hold = 0; m_turn = 0;
    m_g = '0; m_pre = 1'b0;
    prev_g = '0;
  endtask

  task automatic model_step(input logic [3:0] r);
    int   w, h, idx;
    logic take;
    exp_t e;
    take = 1'b0;
    m_pre = 1'b0;
    w = -1;
    for (int k = 0; k < N; k++) begin
      idx = (m_rr + k) % N;
      if (w < 0 && r[idx]) w = idx;
    end
    case (m_st)
      0: if (w >= 0) take = 1'b1;
      1: begin
        h = m_hold;
        if (m_hold < MH) m_hold++;
        if (!r[m_gid]) begin
          m_st = 2; m_turn = TA - 1; m_g = '0;
        end else if (h >= MH - 1 && (r & ~m_g) != '0) begin
          m_st = 2; m_turn = TA - 1; m_g = '0; m_pre = 1'b1;
        end
      end
      default: begin
        if (m_turn == 0) begin
          if (w >= 0) take = 1'b1;
          else        m_st = 0;
        end else m_turn--;
      end
    endcase
    if (take) begin
      m_st = 1; m_gid = w; m_g = 4'b0001 << w; m_rr = (w + 1) % N; m_hold = 0;
    end
    e.g = m_g; e.oe = ~m_g; e.id = 2'(m_gid); e.busy = (m_st == 1); e.pre = m_pre;
    sb.push_back(e);
  endtask

  // Called on the falling edge: drive, predict, let the rising edge pass, compare.
  task automatic cycle(input logic [3:0] r);
    exp_t e;
    req = r;
    model_step(r);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk("sb_empty", 32'(sb.size()), 1);
    end else begin
      e = sb.pop_front();
      chk("grant", grant, e.g);
      chk("oe_n", oe_n, e.oe);
      chk("bus_busy", bus_busy, e.busy);
      chk("preempt", preempt, e.pre);
      if (e.busy) chk("grant_id", grant_id, e.id);
    end
    chk("onehot0", $onehot0(grant), 1);
    if (prev_g != '0 && grant != '0) chk("no_dead_cycle", grant, prev_g);
    if (preempt) n_preempt++;
    prev_g = grant;
    @(negedge clk);
  endtask

  initial begin
    int pre_before;
    model_reset();
    // 1: reset with all requests held, then release
    req = 4'b1111;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_grant", grant, 4'b0000);
    chk("rst_oe_n", oe_n, 4'b1111);
    chk("rst_busy", bus_busy, 1'b0);
    chk("rst_preempt", preempt, 1'b0);
    chk("rst_id", grant_id, 2'd0);
    chk("rst_no_x", $isunknown({grant, oe_n, grant_id, bus_busy, preempt}), 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    cycle(4'b1111);
    chk("first_grant", grant, 4'b0001);
    chk("first_oe_n", oe_n, 4'b1110);
    repeat (3) cycle(4'b0000);

    // 2: holder 0 for three cycles while requester 1 waits
    cycle(4'b0001);
    cycle(4'b0011);
    cycle(4'b0011);
    cycle(4'b0010);
    chk("t2_dead", grant, 4'b0000);
    cycle(4'b0010);
    chk("t2_next", grant, 4'b0010);
    repeat (3) cycle(4'b0000);

    // 3: all requesting, forced rotation every MAX_HOLD cycles
    pre_before = n_preempt;
    repeat (25) cycle(4'b1111);
    chk("t3_preempts", n_preempt - pre_before, 5);
    repeat (3) cycle(4'b0000);

    // 4: lone requester keeps the bus
    pre_before = n_preempt;
    repeat (40) cycle(4'b0100);
    chk("t4_hold", grant, 4'b0100);
    chk("t4_no_preempt", n_preempt - pre_before, 0);
    repeat (3) cycle(4'b0000);

    // 5: holder drops on its last allowed cycle while another waits
    pre_before = n_preempt;
    cycle(4'b0001);
    cycle(4'b0011);
    cycle(4'b0011);
    cycle(4'b0011);
    cycle(4'b0010);
    chk("t5_released", grant, 4'b0000);
    chk("t5_no_preempt", n_preempt - pre_before, 0);
    cycle(4'b0010);
    repeat (3) cycle(4'b0000);

    // random traffic
    repeat (80) cycle(4'($urandom_range(0, 15)));

    // 6: reset mid-grant between edges
    cycle(4'b1000);
    cycle(4'b1000);
    chk("t6_pre_grant", grant, 4'b1000);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_grant", grant, 4'b0000);
    chk("t6_oe_n", oe_n, 4'b1111);
    chk("t6_busy", bus_busy, 1'b0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    cycle(4'b0110);
    chk("t6_restart", grant, 4'b0010);
    repeat (20) cycle(4'($urandom_range(0, 15)));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
